memory_load_sequencer: RTL and testbench
========================================

// Module: memory_load_sequencer
// PURPOSE
//  Sequences the single-port program RAM: after start, streams LOAD_DEPTH bytes from a
//  loader source into RAM at consecutive addresses, then hands RAM to the CPU and
//  releases it from hold. Sits between byte source, CPU memory bus and the RAM macro.
// PARAMETERS
//  ADDR_W      8    RAM address width
//  DATA_W      8    RAM data width
//  LOAD_DEPTH  256  words loaded per start (1..2**ADDR_W)
// PORTS
//  clock_in    in   1       system clock; also driven to mem_clock
//  reset_N     in   1       async active-low reset
//  start       in   1       1-cycle pulse: begin load (honoured in IDLE and RUN only)
//  src_valid   in   1       loader byte valid
//  src_data    in   DATA_W  loader byte
//  src_ready   out  1       byte accepted when src_valid & src_ready
//  cpu_run     out  1       1 = CPU released (RUN state only)
//  cpu_we      in   1       CPU write strobe (ignored unless cpu_run)
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_rdata   out  DATA_W  RAM read data (mem_q passthrough)
//  mem_clock   out  1       = clock_in
//  mem_wr_en   out  1       RAM write enable
//  mem_address out  ADDR_W  RAM address
//  mem_data    out  DATA_W  RAM write data
//  mem_q       in   DATA_W  RAM read data, 1-cycle sync-read latency
//  busy        out  1       1 in LOAD/VERIFY
//  done        out  1       1-cycle pulse on entry to RUN
//  error       out  1       sticky verify failure; cleared by start
// BEHAVIOUR
//  Reset: state IDLE, addr counter 0, src_ready 0, cpu_run 0, mem_wr_en 0, busy 0,
//   done 0, error 0, checksum 0. Reset mid-load abandons load; RAM contents undefined.
//  IDLE: start -> LOAD (counter 0, checksum 0, error 0).
//  LOAD: src_ready=1; each handshake writes src_data at counter same cycle
//   (mem_wr_en=1 combinationally on handshake), counter+1, checksum+=byte (mod 2**DATA_W).
//   src_valid low = stall, no write. Handshake with counter==LOAD_DEPTH-1 -> next state.
//   start during LOAD/VERIFY ignored.
//  RUN: mux selects CPU: mem_address=cpu_addr, mem_data=cpu_wdata, mem_wr_en=cpu_we;
//   cpu_run=1. start in RUN -> LOAD next cycle, cpu_run drops same edge; CPU write in
//   the start cycle still commits.
//  Outside RUN the CPU is fully isolated (no writes reach RAM).
//  Counter is ADDR_W wide; LOAD_DEPTH=2**ADDR_W wraps to 0 exactly at completion.
// CONFIGURATION
//  LOAD_VERIFY_EN defined: LOAD -> VERIFY; reads addr 0..LOAD_DEPTH-1 one per cycle,
//   sums mem_q with 1-cycle lag (LOAD_DEPTH+1 cycles); sum==checksum -> RUN + done,
//   else error=1 -> IDLE (cpu_run stays 0).
//  Undefined: LOAD -> RUN directly; no VERIFY state, checksum logic removed, error tied 0.
// STRUCTURE
//  Package memory_load_pkg: state enum (IDLE, LOAD, VERIFY, RUN), ADDR_W/DATA_W defaults.
//  One sub-module natural: mem_port_mux (loader/verify vs CPU address/data/we select).
//  FSM, counter, checksum in top.
// TESTING (bench: LOAD_DEPTH=4)
//  reset, start, bytes 11,22,33,44 back-to-back -> writes addr 0..3, done after 4th (+5 verify).
//  src_valid gaps (valid 1,0,0,1...) -> no mem_wr_en in gap cycles; addresses still 0..3.
//  RUN: cpu_we=1 addr 0x10 data 0xA5 -> mem_wr_en=1, mem_address 0x10; read returns 0xA5 next.
//  reset_N low after 2 bytes -> IDLE, cpu_run 0, counter 0; new start reloads from addr 0.
//  LOAD_VERIFY_EN: model corrupts addr 2 -> error=1, cpu_run stays 0; start clears error.
//  start in RUN -> cpu_run falls next edge, CPU writes blocked, reload proceeds.

Source files
------------

// File: rtl/memory_load_pkg.sv
// memory_load_pkg: sequencer state encoding and default RAM widths
package memory_load_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, RUN} state_t;
endpackage

// File: rtl/mem_port_mux.sv
// mem_port_mux: steers RAM address/data/write-enable between the sequencer and the CPU
module mem_port_mux
    import memory_load_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              sel_cpu,
    input  logic [ADDR_W-1:0] seq_addr,
    input  logic [DATA_W-1:0] seq_data,
    input  logic              seq_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr_en
);
    always_comb begin
        mem_address = sel_cpu ? cpu_addr : seq_addr;
        mem_data    = sel_cpu ? cpu_wdata : seq_data;
        mem_wr_en   = sel_cpu ? cpu_we : seq_we;
    end
endmodule

// File: rtl/memory_load_sequencer.sv
// memory_load_sequencer: streams LOAD_DEPTH bytes into program RAM then releases the CPU; LOAD_VERIFY_EN adds a checksum read-back pass
module memory_load_sequencer
    import memory_load_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LOAD_DEPTH = 256
) (
    input  logic              clock_in,
    input  logic              reset_N,
    input  logic              start,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              cpu_run,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_clock,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LOAD_DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              src_hs;
`ifdef LOAD_VERIFY_EN
    logic [DATA_W-1:0] chk_q, chk_d, sum_q, sum_d, sum_fin;
    logic              rd_pend_q, rd_pend_d, rd_done_q, rd_done_d, err_q, err_d;
`endif

    always_ff @(posedge clock_in or negedge reset_N) begin
        if (!reset_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
`ifdef LOAD_VERIFY_EN
            chk_q     <= '0;
            sum_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_done_q <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
`ifdef LOAD_VERIFY_EN
            chk_q     <= chk_d;
            sum_q     <= sum_d;
            rd_pend_q <= rd_pend_d;
            rd_done_q <= rd_done_d;
            err_q     <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef LOAD_VERIFY_EN
        chk_d     = chk_q;
        sum_d     = sum_q;
        rd_pend_d = 1'b0;
        rd_done_d = rd_done_q;
        err_d     = err_q;
        sum_fin   = sum_q + mem_q;
`endif
        case (state_q)
            IDLE, RUN: if (start) begin
                state_d = LOAD;
                cnt_d   = '0;
`ifdef LOAD_VERIFY_EN
                chk_d   = '0;
                err_d   = 1'b0;
`endif
            end
            LOAD: if (src_hs) begin
                cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
`ifdef LOAD_VERIFY_EN
                chk_d = chk_q + src_data;
                if (cnt_q == LAST) begin
                    state_d   = VERIFY;
                    sum_d     = '0;
                    rd_done_d = 1'b0;
                end
`else
                if (cnt_q == LAST) state_d = RUN;
`endif
            end
`ifdef LOAD_VERIFY_EN
            // Reads issue for LOAD_DEPTH cycles; the extra cycle folds in the last mem_q.
            VERIFY: begin
                if (!rd_done_q) begin
                    cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                    rd_pend_d = 1'b1;
                    rd_done_d = cnt_q == LAST;
                end
                if (rd_pend_q) sum_d = sum_fin;
                if (rd_done_q && rd_pend_q) begin
                    state_d = (sum_fin == chk_q) ? RUN : IDLE;
                    err_d   = sum_fin != chk_q;
                end
            end
`endif
            default: ;
        endcase
        done_d = (state_d == RUN) && (state_q != RUN);
    end

    always_comb begin
        src_ready = state_q == LOAD;
        cpu_run   = state_q == RUN;
        busy      = (state_q == LOAD) || (state_q == VERIFY);
        src_hs    = src_valid && (state_q == LOAD);
    end

    mem_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
        .sel_cpu     (cpu_run),
        .seq_addr    (cnt_q),
        .seq_data    (src_data),
        .seq_we      (src_hs),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_we      (cpu_we),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wr_en   (mem_wr_en)
    );

    assign cpu_rdata = mem_q;
    assign mem_clock = clock_in;
    assign done      = done_q;
`ifdef LOAD_VERIFY_EN
    assign error = err_q;
`else
    assign error = 1'b0;
`endif
endmodule

// File: tb/tb_memory_load_sequencer.sv
// tb_memory_load_sequencer: random + directed stimulus checked against a phase-level model of the load sequencer
module tb_memory_load_sequencer;
    localparam int DEPTH = 4;
`ifdef LOAD_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    localparam int LAT = VER ? DEPTH + 5 : DEPTH;

    logic       clock_in = 1'b0, reset_N = 1'b0, start = 1'b0, src_valid = 1'b0, cpu_we = 1'b0;
    logic [7:0] src_data = '0, cpu_addr = '0, cpu_wdata = '0, mem_q = '0;
    logic       src_ready, cpu_run, mem_clock, mem_wr_en, busy, done, error;
    logic [7:0] cpu_rdata, mem_address, mem_data;

    memory_load_sequencer #(.ADDR_W(8), .DATA_W(8), .LOAD_DEPTH(DEPTH)) dut (
        .clock_in(clock_in), .reset_N(reset_N), .start(start), .src_valid(src_valid),
        .src_data(src_data), .src_ready(src_ready), .cpu_run(cpu_run), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .mem_clock(mem_clock),
        .mem_wr_en(mem_wr_en), .mem_address(mem_address), .mem_data(mem_data), .mem_q(mem_q),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clock_in = ~clock_in;

    logic [7:0] ram [256];
    logic       corrupt = 1'b0;
    initial for (int i = 0; i < 256; i++) ram[i] = '0;
    always @(posedge clock_in) begin
        if (mem_wr_en) ram[mem_address] <= (corrupt && mem_address == 8'd2) ? mem_data ^ 8'hFF : mem_data;
        mem_q <= ram[mem_address];
    end

    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 loading, 2 verifying, 3 CPU running
    int         ph = 0, n = 0, v = 0;
    logic       done_m = 1'b0, err_m = 1'b0, rd_ok = 1'b0;
    logic [7:0] rd_exp = '0, exp_mem [256];
    initial for (int i = 0; i < 256; i++) exp_mem[i] = '0;

    always @(posedge clock_in or negedge reset_N) begin
        if (!reset_N) begin
            ph = 0; n = 0; v = 0; done_m = 0; err_m = 0; rd_ok = 0;
        end else begin
            done_m = 0;
            rd_ok  = 0;
            case (ph)
                0: if (start) begin ph = 1; n = 0; err_m = 0; end
                1: if (src_valid) begin
                    exp_mem[n] = src_data;
                    n++;
                    if (n == DEPTH) begin
                        if (VER) begin ph = 2; v = 0; end
                        else begin ph = 3; done_m = 1; end
                    end
                end
                2: if (v == DEPTH) begin
                    int s_ram, s_ld;
                    s_ram = 0; s_ld = 0;
                    for (int i = 0; i < DEPTH; i++) begin s_ram += ram[i]; s_ld += exp_mem[i]; end
                    if (s_ram[7:0] == s_ld[7:0]) begin ph = 3; done_m = 1; end
                    else begin ph = 0; err_m = 1; end
                end else v++;
                default: begin
                    rd_ok  = 1;
                    rd_exp = exp_mem[cpu_addr];
                    if (cpu_we) exp_mem[cpu_addr] = cpu_wdata;
                    if (start) begin ph = 1; n = 0; err_m = 0; end
                end
            endcase
        end
    end

    always @(negedge clock_in) if (reset_N) begin
        chk("src_ready", src_ready, ph == 1);
        chk("cpu_run", cpu_run, ph == 3);
        chk("busy", busy, ph == 1 || ph == 2);
        chk("done", done, done_m);
        chk("error", error, err_m);
        chk("mem_wr_en", mem_wr_en, ph == 1 ? src_valid : ph == 3 ? cpu_we : 1'b0);
        if (ph == 1 && src_valid) begin
            chk("load_addr", mem_address, n);
            chk("load_data", mem_data, src_data);
        end
        if (ph == 3) begin
            chk("cpu_addr_mux", mem_address, cpu_addr);
            chk("cpu_data_mux", mem_data, cpu_wdata);
        end
        if (ph == 2 && v < DEPTH) chk("verify_addr", mem_address, v);
        if (rd_ok) chk("cpu_rdata", cpu_rdata, rd_exp);
    end

    task automatic cyc();
        @(posedge clock_in);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b);
        src_valid = 1'b1;
        src_data  = b;
        cyc();
        src_valid = 1'b0;
    endtask

    task automatic wait_run(input string nm);
        int k;
        k = 0;
        while (!cpu_run && k < 40) begin cyc(); k++; end
        chk(nm, cpu_run, 1'b1);
    endtask

    initial begin
        int k;
        logic [7:0] bytes [4];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        cyc(); cyc();
        chk("rst_src_ready", src_ready, 1'b0);
        chk("rst_cpu_run", cpu_run, 1'b0);
        chk("rst_wr_en", mem_wr_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        reset_N = 1'b1;
        cyc();

        // back-to-back load of 11,22,33,44 with done latency counted from the start edge
        pulse_start();
        for (int i = 0; i < 4; i++) feed(bytes[i]);
        k = DEPTH;
        while (!done && k < 40) begin cyc(); k++; end
        chk("done_latency", k, LAT);
        chk("run_after_load", cpu_run, 1'b1);
        for (int i = 0; i < 4; i++) chk("ram_load", ram[i], bytes[i]);
        chk("model_pin", exp_mem[3], 8'h44);

        // CPU write then read-back in RUN
        cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
        cyc();
        cpu_we = 1'b0;
        cyc();
        chk("cpu_readback", cpu_rdata, 8'hA5);

        // start in RUN: write in the start cycle commits, CPU then isolated during reload with gaps
        cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h3C;
        pulse_start();
        chk("run_drop", cpu_run, 1'b0);
        chk("start_cycle_write", ram[8'h20], 8'h3C);
        cpu_wdata = 8'hEE; cpu_addr = 8'h01;
        feed(8'h55); cyc(); cyc(); feed(8'h66); cyc(); feed(8'h77); feed(8'h88);
        cpu_we = 1'b0;
        wait_run("gap_run");
        chk("gap_ram1", ram[1], 8'h66);
        chk("gap_ram3", ram[3], 8'h88);

        // reset mid-load, then reload from address 0
        pulse_start();
        feed(8'h01); feed(8'h02);
        reset_N = 1'b0;
        #1;
        chk("midrst_cpu_run", cpu_run, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        cyc();
        reset_N = 1'b1;
        cyc();
        pulse_start();
        feed(8'h9A); feed(8'h9B); feed(8'h9C); feed(8'h9D);
        wait_run("reload_run");
        chk("reload_ram0", ram[0], 8'h9A);

        if (VER) begin
            corrupt = 1'b1;
            pulse_start();
            for (int i = 0; i < 4; i++) feed(bytes[i]);
            corrupt = 1'b0;
            k = 0;
            while (!error && k < 20) begin cyc(); k++; end
            chk("verify_error", error, 1'b1);
            cyc();
            chk("verify_no_run", cpu_run, 1'b0);
            pulse_start();
            chk("start_clears_error", error, 1'b0);
            for (int i = 0; i < 4; i++) feed(bytes[i]);
            wait_run("verify_ok_run");
        end

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            start     = $urandom_range(0, 19) == 0;
            src_valid = $urandom_range(0, 3) != 0;
            src_data  = 8'($urandom);
            cpu_we    = $urandom_range(0, 1) == 1;
            cpu_addr  = 8'($urandom_range(0, 15));
            cpu_wdata = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                reset_N = 1'b0;
                cyc();
                reset_N = 1'b1;
            end
            cyc();
        end
        start = 1'b0;
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
